// File: rtl/memory_mb_arb.sv
// Multi-port, multi-bank word memory with a round-robin arbiter per bank.
// Latency: read accepted in cycle N returns in N+1 (N+2 with MEM_MB_ARB_OUT_REG_EN).
// Backpressure: req_ready is low for a port that loses its bank's arbitration or while rst is high.
//
// Ports:
//   clk, rst                 sole clock, synchronous active-high reset
//   req_valid/req_ready      per-port request handshake
//   req_we/req_addr/req_wdata  request payload (write enable, global word address, write data)
//   rsp_valid/rsp_rdata      per-port registered read response; rsp_rdata holds while rsp_valid=0
// Optional macro: MEM_MB_ARB_OUT_REG_EN adds a second output register stage.
module memory_mb_arb #(
    parameter int data_bit_width   = 32,
    parameter int num_banks        = 4,
    parameter int num_bank_entries = 8,
    parameter int num_ports        = 2,
    parameter int bank_bits        = $clog2(num_banks),
    parameter int addr_bit_width   = $clog2(num_banks * num_bank_entries)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [num_ports-1:0]      req_valid,
    output logic [num_ports-1:0]      req_ready,
    input  logic [num_ports-1:0]      req_we,
    input  logic [addr_bit_width-1:0] req_addr  [num_ports],
    input  logic [data_bit_width-1:0] req_wdata [num_ports],
    output logic [num_ports-1:0]      rsp_valid,
    output logic [data_bit_width-1:0] rsp_rdata [num_ports]
);

    localparam int row_bits  = addr_bit_width - bank_bits;
    localparam int port_bits = (num_ports > 1) ? $clog2(num_ports) : 1;

    logic [bank_bits-1:0]      bank_of  [num_ports];
    logic [row_bits-1:0]       row_of   [num_ports];
    logic [num_ports-1:0]      grant    [num_banks];
    logic [port_bits-1:0]      rr_ptr_q [num_banks];
    logic [port_bits-1:0]      rr_ptr_d [num_banks];
    logic [num_ports-1:0]      rd_acc;
    logic [num_ports-1:0]      rsp_vld_q;
    logic [data_bit_width-1:0] rsp_dat_q [num_ports];
    logic [data_bit_width-1:0] mem_q     [num_banks][num_bank_entries];

    logic                      found;
    logic [port_bits-1:0]      idx;
    int                        cand;

    // Low-order interleave: consecutive addresses land in consecutive banks.
    always_comb begin
        for (int p = 0; p < num_ports; p++) begin
            bank_of[p] = req_addr[p][bank_bits-1:0];
            row_of[p]  = req_addr[p][addr_bit_width-1:bank_bits];
        end
    end

    // Per-bank round-robin: scan ports upward from rr_ptr, first candidate wins.
    // rr_ptr never exceeds num_ports-1, so one subtraction is enough for the wrap.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int b = 0; b < num_banks; b++) begin
            grant[b]    = '0;
            rr_ptr_d[b] = rr_ptr_q[b];
            found       = 1'b0;
            for (int i = 0; i < num_ports; i++) begin
                cand = int'(rr_ptr_q[b]) + i;
                if (cand >= num_ports) begin
                    cand = cand - num_ports;
                end
                idx = port_bits'(cand);
                if (!found && req_valid[idx] && (bank_of[idx] == bank_bits'(b))) begin
                    grant[b][idx] = 1'b1;
                    found         = 1'b1;
                    rr_ptr_d[b]   = (cand + 1 >= num_ports) ? '0 : port_bits'(cand + 1);
                end
            end
        end
    end

    // A port targets exactly one bank, so its ready is that bank's grant bit.
    always_comb begin
        for (int p = 0; p < num_ports; p++) begin
            req_ready[p] = ~rst & grant[bank_of[p]][p];
            rd_acc[p]    = req_ready[p] & ~req_we[p];
        end
    end

    // Storage is deliberately not reset. Writes are gated by req_ready, which is low in reset.
    always_ff @(posedge clk) begin
        for (int p = 0; p < num_ports; p++) begin
            if (req_ready[p] && req_we[p]) begin
                mem_q[bank_of[p]][row_of[p]] <= req_wdata[p];
            end
        end
    end

    // First response stage; the array read sees writes from earlier cycles only,
    // and one grant per bank rules out a same-cycle write to the bank being read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_vld_q <= '0;
            for (int b = 0; b < num_banks; b++) begin
                rr_ptr_q[b] <= '0;
            end
            for (int p = 0; p < num_ports; p++) begin
                rsp_dat_q[p] <= '0;
            end
        end else begin
            rsp_vld_q <= rd_acc;
            for (int b = 0; b < num_banks; b++) begin
                rr_ptr_q[b] <= rr_ptr_d[b];
            end
            for (int p = 0; p < num_ports; p++) begin
                if (rd_acc[p]) begin
                    rsp_dat_q[p] <= mem_q[bank_of[p]][row_of[p]];
                end
            end
        end
    end

`ifdef MEM_MB_ARB_OUT_REG_EN
    logic [num_ports-1:0]      out_vld_q;
    logic [data_bit_width-1:0] out_dat_q [num_ports];

    // Extra stage only loads on valid so the hold rule applies at the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q <= '0;
            for (int p = 0; p < num_ports; p++) begin
                out_dat_q[p] <= '0;
            end
        end else begin
            out_vld_q <= rsp_vld_q;
            for (int p = 0; p < num_ports; p++) begin
                if (rsp_vld_q[p]) begin
                    out_dat_q[p] <= rsp_dat_q[p];
                end
            end
        end
    end

    assign rsp_valid = out_vld_q;
    always_comb begin
        for (int p = 0; p < num_ports; p++) begin
            rsp_rdata[p] = out_dat_q[p];
        end
    end
`else
    assign rsp_valid = rsp_vld_q;
    always_comb begin
        for (int p = 0; p < num_ports; p++) begin
            rsp_rdata[p] = rsp_dat_q[p];
        end
    end
`endif

endmodule
